// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, status bit
// positions, oversampling points and word-length limits.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP1,
        RX_STOP2
    } rx_state_e;

    localparam int ST_EMPTY_BIT   = 4;
    localparam int ST_FULL_BIT    = 5;
    localparam int ST_OVERRUN_BIT = 6;
    localparam int ST_FRAMING_BIT = 7;

    localparam logic [3:0] OVS16_LAST  = 4'd15;
    localparam logic [3:0] OVS16_SMP0  = 4'd7;
    localparam logic [3:0] OVS16_SMP1  = 4'd8;
    localparam logic [3:0] OVS16_SMP2  = 4'd9;
    localparam logic [3:0] OVS3_LAST   = 4'd2;
    localparam logic [3:0] OVS3_SAMPLE = 4'd1;

    localparam logic [3:0] MIN_WL = 4'd5;
    localparam logic [3:0] MAX_WL = 4'd8;

    // Out-of-range word lengths saturate into the legal 5..8 window.
    function automatic logic [3:0] clamp_wl(input logic [4:0] wl);
        if (wl < {1'b0, MIN_WL}) begin
            return MIN_WL;
        end else if (wl > {1'b0, MAX_WL}) begin
            return MAX_WL;
        end else begin
            return wl[3:0];
        end
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead byte FIFO; rdata presents the head entry (0 when empty).
module uart_rx_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int         DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: rxd synchroniser, oversampled deframing FSM and an 8-entry
// receive FIFO with sticky overrun/framing flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       baud_tick,
    input  logic [4:0] word_length,
    input  logic       Num_stop_bits,
    input  logic       oversample_by_3,
    input  logic       enable_uart,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic [7:0] fifo_status,
    output logic       data_valid,
    output logic       intr
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_e              state_q, state_d;
    logic [3:0]             smp_cnt_q, smp_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [3:0]             wl_q, wl_d;
    logic                   two_stop_q, two_stop_d;
    logic                   ovs3_q, ovs3_d;
    logic [7:0]             shift_q, shift_d;
    logic [1:0]             maj_q, maj_d;
    logic                   overrun_q, overrun_d;
    logic                   framing_q, framing_d;

    logic                   rx_s, bit_val, at_decide, at_end;
    logic                   push, framing_set, overrun_set;
    logic [FIFO_AW:0]       fifo_count;
    logic                   fifo_full, fifo_empty;

    uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .wdata (shift_q),
        .rdata (rd_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], rxd};
        rx_s        = sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        smp_cnt_d   = smp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        wl_d        = wl_q;
        two_stop_d  = two_stop_q;
        ovs3_d      = ovs3_q;
        shift_d     = shift_q;
        maj_d       = maj_q;
        push        = 1'b0;
        framing_set = 1'b0;

        at_decide = ovs3_q ? (smp_cnt_q == OVS3_SAMPLE) : (smp_cnt_q == OVS16_SMP2);
        at_end    = ovs3_q ? (smp_cnt_q == OVS3_LAST) : (smp_cnt_q == OVS16_LAST);
        bit_val   = ovs3_q ? rx_s
                  : ((maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s));

        if (baud_tick) begin
            if (state_q != RX_IDLE) begin
                smp_cnt_d = at_end ? 4'd0 : smp_cnt_q + 4'd1;
                if (smp_cnt_q == OVS16_SMP0) maj_d[0] = rx_s;
                if (smp_cnt_q == OVS16_SMP1) maj_d[1] = rx_s;
            end
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s && enable_uart) begin
                        state_d    = RX_START;
                        smp_cnt_d  = 4'd0;
                        bit_cnt_d  = 3'd0;
                        shift_d    = 8'h00;
                        wl_d       = clamp_wl(word_length);
                        two_stop_d = Num_stop_bits;
                        ovs3_d     = oversample_by_3;
                    end
                end
                RX_START: begin
                    if (at_decide && bit_val) begin
                        state_d = RX_IDLE;
                    end else if (at_end) begin
                        state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (at_decide) begin
                        shift_d[bit_cnt_q] = bit_val;
                    end
                    if (at_end) begin
                        if ({1'b0, bit_cnt_q} == wl_q - 4'd1) begin
                            state_d = RX_STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // Stop decisions return to IDLE mid-bit so a following start edge is not missed.
                RX_STOP1: begin
                    if (at_decide) begin
                        if (!bit_val) begin
                            framing_set = 1'b1;
                            state_d     = RX_IDLE;
                        end else if (!two_stop_q) begin
                            push    = 1'b1;
                            state_d = RX_IDLE;
                        end
                    end else if (at_end) begin
                        state_d = RX_STOP2;
                    end
                end
                RX_STOP2: begin
                    if (at_decide) begin
                        framing_set = !bit_val;
                        push        = bit_val;
                        state_d     = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end

        if (!enable_uart) begin
            state_d     = RX_IDLE;
            push        = 1'b0;
            framing_set = 1'b0;
        end

        // Bus side pops with rd_en while data_valid is high; a pop of an empty FIFO is ignored.
        overrun_set = push && fifo_full && !rd_en;
        overrun_d   = (overrun_q && !clr_err) || overrun_set;
        framing_d   = (framing_q && !clr_err) || framing_set;

        fifo_status                 = 8'h00;
        fifo_status[3:0]            = fifo_count[3:0];
        fifo_status[ST_EMPTY_BIT]   = fifo_empty;
        fifo_status[ST_FULL_BIT]    = fifo_full;
        fifo_status[ST_OVERRUN_BIT] = overrun_q;
        fifo_status[ST_FRAMING_BIT] = framing_q;
        data_valid                  = !fifo_empty;
        intr                        = data_valid || overrun_q || framing_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            state_q    <= RX_IDLE;
            smp_cnt_q  <= 4'd0;
            bit_cnt_q  <= 3'd0;
            wl_q       <= MAX_WL;
            two_stop_q <= 1'b0;
            ovs3_q     <= 1'b0;
            shift_q    <= 8'h00;
            maj_q      <= 2'b00;
            overrun_q  <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            wl_q       <= wl_d;
            two_stop_q <= two_stop_d;
            ovs3_q     <= ovs3_d;
            shift_q    <= shift_d;
            maj_q      <= maj_d;
            overrun_q  <= overrun_d;
            framing_q  <= framing_d;
        end
    end

endmodule
